// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory request/response bundle.
// master: MEM stage (drives req_*), slave: responder (drives req_ready, rsp_*).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word-organised data RAM answering one MEM-stage load/store at a time.
// Ports: clk, reset (async active-low), bus (slave side of the request/response bundle), busy.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic                 busy
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam bit          DIRECT   = (LATENCY == 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        op_wr;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        bad_f3;
    logic        misalign;
    logic        out_range;
    logic        op_err;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;

    // The operation being committed: with LATENCY=1 the commit happens on the
    // accept edge itself, so the live inputs stand in for the latched copy.
    always_comb begin
        accept   = bus.req_valid && (state_q == S_IDLE);
        op_wr    = (state_q == S_IDLE) ? bus.req_write  : wr_q;
        op_f3    = (state_q == S_IDLE) ? bus.req_funct3 : f3_q;
        op_addr  = (state_q == S_IDLE) ? bus.req_addr   : addr_q;
        op_wdata = (state_q == S_IDLE) ? bus.req_wdata  : wdata_q;

        commit = reset && ((state_q == S_WAIT && cnt_q == 4'd0) ||
                           (DIRECT && accept));

        bad_f3 = 1'b1;
        unique case (op_f3)
            3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
            3'b100, 3'b101:         bad_f3 = op_wr;
            default:                bad_f3 = 1'b1;
        endcase

        misalign  = (op_f3[1:0] == 2'b01 && op_addr[0]) ||
                    (op_f3 == 3'b010 && op_addr[1:0] != 2'b00);
        out_range = {1'b0, op_addr} >= LIMIT;
        op_err    = bad_f3 || misalign || out_range;

        idx     = op_addr[AW+1:2];
        word    = mem[idx];
        shifted = word >> {op_addr[1:0], 3'b000};

        load_val = 32'd0;
        unique case (op_f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase

        lane_en = 4'b0000;
        unique case (op_f3[1:0])
            2'b00:   lane_en = 4'b0001 << op_addr[1:0];
            2'b01:   lane_en = 4'b0011 << {op_addr[1], 1'b0};
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
        // Right-aligned store data moved onto its byte lanes.
        lane_data = op_wdata << {op_addr[1:0], 3'b000};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = bus.req_write;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = DIRECT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Response registers are only non-zero in the single RESP cycle.
        rdata_d = (commit && !op_wr && !op_err) ? load_val : 32'd0;
        err_d   = commit && op_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; commit is already gated by reset.
    always_ff @(posedge clk) begin
        if (commit && op_wr && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = err_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-array memory model.
// Runs one LATENCY=2 and one LATENCY=1 instance side by side.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if b2 ();
    data_mem_responder_if b1 ();
    logic busy2;
    logic busy1;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(b2), .busy(busy2)
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_mem [4096];

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    function automatic bit model_err(bit wr, logic [2:0] f3, logic [31:0] a);
        int n;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (!wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        n = 1 << f3[1:0];
        if ((a % n) != 0) return 1'b1;
        if (a >= 32'd4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a);
        longint v = 0;
        int n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8 * i);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
    endtask

    task automatic drive_bus(int L, logic v, logic wr, logic [2:0] f3,
                             logic [31:0] a, logic [31:0] wd);
        if (L == 1) begin
            b1.req_valid = v; b1.req_write = wr; b1.req_funct3 = f3;
            b1.req_addr = a; b1.req_wdata = wd;
        end else begin
            b2.req_valid = v; b2.req_write = wr; b2.req_funct3 = f3;
            b2.req_addr = a; b2.req_wdata = wd;
        end
    endtask

    task automatic sample_bus(int L, output logic rdy, output logic rv,
                              output logic [31:0] rdat, output logic re);
        if (L == 1) begin
            rdy = b1.req_ready; rv = b1.rsp_valid; rdat = b1.rsp_rdata; re = b1.rsp_error;
        end else begin
            rdy = b2.req_ready; rv = b2.rsp_valid; rdat = b2.rsp_rdata; re = b2.rsp_error;
        end
    endtask

    // One request on the LATENCY=2 instance; lat counts edges after accept.
    task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic er, output int lat, output logic [31:0] rd_after);
        int g = 0;
        @(negedge clk);
        while (!b2.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        drive_bus(2, 1'b1, wr, f3, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive_bus(2, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
        lat = 0;
        while (!b2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = b2.rsp_rdata;
        er = b2.rsp_error;
        @(negedge clk);
        rd_after = b2.rsp_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_bus(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_bus(2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #12;
        checks++;
        if (b2.req_ready !== 1'b1 || b2.rsp_valid !== 1'b0 || b2.rsp_rdata !== 32'd0 ||
            b2.rsp_error !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_l2: rdy=%b rv=%b rd=%h er=%b busy=%b want 1 0 0 0 0",
                     b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.rsp_error, busy2);
        end
        checks++;
        if (b1.req_ready !== 1'b1 || b1.rsp_valid !== 1'b0 || b1.rsp_rdata !== 32'd0 ||
            b1.rsp_error !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_l1: rdy=%b rv=%b rd=%h er=%b busy=%b want 1 0 0 0 0",
                     b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_error, busy1);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_abort();
        logic [31:0] rd, rda;
        logic er;
        int lat;
        int g = 0;
        issue(1'b1, 3'd2, 32'h10, 32'h01020304, rd, er, lat, rda);
        model_store(3'd2, 32'h10, 32'h01020304);
        checks++;
        if (er !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL abort_pre_store: er=%b lat=%0d want 0 2", er, lat);
        end
        @(negedge clk);
        while (!b2.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        drive_bus(2, 1'b1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        drive_bus(2, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: busy=%b want 1", busy2);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (b2.req_ready !== 1'b1 || b2.rsp_valid !== 1'b0 || b2.rsp_rdata !== 32'd0 ||
            b2.rsp_error !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset_outputs: rdy=%b rv=%b rd=%h er=%b busy=%b want 1 0 0 0 0",
                     b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.rsp_error, busy2);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 3'd2, 32'h10, 32'd0, rd, er, lat, rda);
        checks++;
        if (rd !== 32'h01020304 || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write: rd=%h er=%b want 01020304 0", rd, er);
        end
    endtask

    task automatic test_spec_vectors();
        vec_t tbl [17];
        logic [31:0] rd, rda;
        logic er;
        int lat;
        tbl = '{
            '{1'b1, 3'd2, 32'h20,   32'h876543A1, 32'h00000000, 1'b0},
            '{1'b0, 3'd2, 32'h20,   32'h0,        32'h876543A1, 1'b0},
            '{1'b0, 3'd0, 32'h20,   32'h0,        32'hFFFFFFA1, 1'b0},
            '{1'b0, 3'd4, 32'h20,   32'h0,        32'h000000A1, 1'b0},
            '{1'b0, 3'd1, 32'h22,   32'h0,        32'hFFFF8765, 1'b0},
            '{1'b0, 3'd5, 32'h22,   32'h0,        32'h00008765, 1'b0},
            '{1'b1, 3'd0, 32'h21,   32'h55,       32'h00000000, 1'b0},
            '{1'b0, 3'd2, 32'h20,   32'h0,        32'h876555A1, 1'b0},
            '{1'b1, 3'd1, 32'h22,   32'h1234,     32'h00000000, 1'b0},
            '{1'b0, 3'd2, 32'h20,   32'h0,        32'h123455A1, 1'b0},
            '{1'b0, 3'd2, 32'h22,   32'h0,        32'h00000000, 1'b1},
            '{1'b0, 3'd1, 32'h23,   32'h0,        32'h00000000, 1'b1},
            '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h00000000, 1'b1},
            '{1'b0, 3'd3, 32'h20,   32'h0,        32'h00000000, 1'b1},
            '{1'b1, 3'd2, 32'h22,   32'hFFFFFFFF, 32'h00000000, 1'b1},
            '{1'b1, 3'd4, 32'h20,   32'hFFFFFFFF, 32'h00000000, 1'b1},
            '{1'b0, 3'd2, 32'h20,   32'h0,        32'h123455A1, 1'b0}
        };
        for (int i = 0; i < 17; i++) begin
            issue(tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat, rda);
            if (tbl[i].wr && !tbl[i].er) model_store(tbl[i].f3, tbl[i].a, tbl[i].wd);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL spec_latency[%0d]: lat=%0d want 2", i, lat);
            end
            checks++;
            if (rd !== tbl[i].rd || er !== tbl[i].er) begin
                errors++;
                $display("FAIL spec_data[%0d]: rd=%h er=%b want %h %b",
                         i, rd, er, tbl[i].rd, tbl[i].er);
            end
            checks++;
            if (rda !== 32'd0) begin
                errors++;
                $display("FAIL spec_idle_zero[%0d]: rd=%h want 0", i, rda);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, rda, a, wd, exp_rd;
        logic [2:0] f3;
        logic er;
        bit wr, exp_er;
        int lat, kind, n;
        logic [2:0] ld_set [5];
        ld_set = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            issue(1'b1, 3'd2, 32'(4 * w), wd, rd, er, lat, rda);
            model_store(3'd2, 32'(4 * w), wd);
            checks++;
            if (er !== 1'b0) begin
                errors++;
                $display("FAIL rand_init[%0d]: er=%b want 0", w, er);
            end
        end
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 9);
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? 3'($urandom_range(0, 2)) : ld_set[$urandom_range(0, 4)];
            n = 1 << f3[1:0];
            a = 32'($urandom_range(0, 255));
            a = a - (a % n);
            wd = $urandom;
            if (kind == 0) a = $urandom;
            if (kind == 1) f3 = 3'($urandom);
            if (kind == 2) a = 32'($urandom_range(4090, 4200));
            exp_er = model_err(wr, f3, a);
            exp_rd = (!wr && !exp_er) ? model_load(f3, a) : 32'd0;
            issue(wr, f3, a, wd, rd, er, lat, rda);
            if (wr && !exp_er) model_store(f3, a, wd);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL rand_latency[%0d]: lat=%0d want 2", k, lat);
            end
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                errors++;
                $display("FAIL rand_data[%0d] wr=%b f3=%0d a=%h: rd=%h er=%b want %h %b",
                         k, wr, f3, a, rd, er, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_back_to_back(input int L);
        int p = (L == 1) ? 2 : L + 2;
        int g = 0;
        int lat;
        logic rdy, rv, re;
        logic [31:0] rdat;
        logic [31:0] val;
        val = $urandom;
        @(negedge clk);
        sample_bus(L, rdy, rv, rdat, re);
        while (!rdy && g < 20) begin
            @(negedge clk);
            g++;
            sample_bus(L, rdy, rv, rdat, re);
        end
        drive_bus(L, 1'b1, 1'b1, 3'd2, 32'h100, val);
        for (int c = 0; c < 3 * p; c++) begin
            sample_bus(L, rdy, rv, rdat, re);
            checks++;
            if (rdy !== (c % p == 0) || rv !== (c % p == p - 1)) begin
                errors++;
                $display("FAIL b2b_L%0d[%0d]: rdy=%b rv=%b want %b %b",
                         L, c, rdy, rv, (c % p == 0), (c % p == p - 1));
            end
            if (c % p == p - 1) begin
                checks++;
                if (re !== 1'b0 || rdat !== 32'd0) begin
                    errors++;
                    $display("FAIL b2b_rsp_L%0d[%0d]: rd=%h er=%b want 0 0", L, c, rdat, re);
                end
            end
            @(negedge clk);
        end
        drive_bus(L, 1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_bus(L, 1'b0, 1'b1, 3'd0, 32'h0, 32'd0);
        lat = 0;
        sample_bus(L, rdy, rv, rdat, re);
        while (!rv && lat < 20) begin
            @(negedge clk);
            lat++;
            sample_bus(L, rdy, rv, rdat, re);
        end
        checks++;
        if (lat != ((L == 1) ? 0 : L) || rdat !== val || re !== 1'b0) begin
            errors++;
            $display("FAIL b2b_readback_L%0d: lat=%0d rd=%h er=%b want %0d %h 0",
                     L, lat, rdat, re, (L == 1) ? 0 : L, val);
        end
        if (L == 2) model_store(3'd2, 32'h100, val);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_abort();
        test_spec_vectors();
        test_random();
        test_back_to_back(2);
        test_back_to_back(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
